sig_control_gen: RTL and testbench

Parametrised successor to the highway/country-road signal controller. It uses a single timed Moore FSM with a shared dwell timer and replaces the per-phase ad-hoc counters. New behaviour over the previous generation:
- minimum highway green before serving the country road;
- maximum country green timeout, so a stuck sensor cannot starve the highway;
- all-red clearance on both sides of the country phase;
- a night flash mode.

The block sits between the road sensor and the signal-head drivers.

---
 rtl/sig_control_gen.sv | 122 ++++++++++++
 tb/tb_sig_control_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sig_control_gen.sv
// Highway/country-road signal controller: one timed Moore FSM sharing a
// saturating dwell timer, with all-red clearance, country timeout and night flash.
module sig_control_gen #(
  parameter int unsigned DLY_W      = 3,
  parameter int unsigned TMR_W      = 8,
  parameter int unsigned FLASH_HALF = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             X,
  input  logic             night_mode,
  input  logic [DLY_W-1:0] y2rdelay,
  input  logic [DLY_W-1:0] r2gdelay,
  input  logic [TMR_W-1:0] min_hwy_green,
  input  logic [TMR_W-1:0] max_cntry_green,
  output logic [1:0]       hwy,
  output logic [1:0]       cntry,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5,
    FL  = 3'd6,
    BAD = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    L_RED = 2'd0,
    L_YEL = 2'd1,
    L_GRN = 2'd2,
    L_OFF = 2'd3
  } lamp_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             phase_q, phase_d;
  logic             toggle;
  logic [TMR_W-1:0] y2r, r2g, flash_end;
  lamp_t            hwy_c, cntry_c;

  assign y2r       = TMR_W'(y2rdelay);
  assign r2g       = TMR_W'(r2gdelay);
  assign flash_end = TMR_W'(FLASH_HALF - 1);

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= HG;
      tmr_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    toggle  = 1'b0;
    unique case (state_q)
      HG: begin
        if (night_mode)                        state_d = FL;
        else if (X && (tmr_q >= min_hwy_green)) state_d = HY;
      end
      HY:  if (tmr_q >= y2r) state_d = AR1;
      AR1: if (tmr_q >= r2g) state_d = CG;
      CG: begin
        if (!X) state_d = CY;
        else if ((max_cntry_green != '0) && (tmr_q >= max_cntry_green)) state_d = CY;
      end
      CY:  if (tmr_q >= y2r) state_d = AR2;
      AR2: if (tmr_q >= r2g) state_d = HG;
      FL: begin
        if (!night_mode) state_d = AR2;
        else if (tmr_q == flash_end) begin
          phase_d = ~phase_q;
          toggle  = 1'b1;
        end
      end
      default: state_d = HG;
    endcase

    // Phase is meaningful only inside FL; clearing it on any state change
    // guarantees FL is always entered in phase 0.
    if (state_d != state_q) phase_d = 1'b0;

    if ((state_d != state_q) || toggle) tmr_d = '0;
    else if (tmr_q != '1)               tmr_d = tmr_q + TMR_W'(1);
    else                                tmr_d = tmr_q;
  end

  always_comb begin
    hwy_c   = L_RED;
    cntry_c = L_RED;
    unique case (state_q)
      HG:  hwy_c   = L_GRN;
      HY:  hwy_c   = L_YEL;
      CG:  cntry_c = L_GRN;
      CY:  cntry_c = L_YEL;
      FL: begin
        if (phase_q) begin
          hwy_c   = L_OFF;
          cntry_c = L_OFF;
        end else begin
          hwy_c   = L_YEL;
        end
      end
      default: ;
    endcase
  end

  assign hwy     = hwy_c;
  assign cntry   = cntry_c;
  assign state_o = state_q;

endmodule

// File: tb/tb_sig_control_gen.sv
// Directed bench for sig_control_gen: walks the full signal cycle, timeout,
// night flash, mid-state resets and zero-delay corners against hand-derived values.
module tb_sig_control_gen;

  localparam int unsigned DLY_W = 3;
  localparam int unsigned TMR_W = 8;

  logic             clock = 1'b0;
  logic             clear;
  logic             X;
  logic             night_mode;
  logic [DLY_W-1:0] y2rdelay;
  logic [DLY_W-1:0] r2gdelay;
  logic [TMR_W-1:0] min_hwy_green;
  logic [TMR_W-1:0] max_cntry_green;
  logic [1:0]       hwy;
  logic [1:0]       cntry;
  logic [2:0]       state_o;

  int n_tests = 0;
  int n_fail  = 0;

  sig_control_gen #(
    .DLY_W      (DLY_W),
    .TMR_W      (TMR_W),
    .FLASH_HALF (2)
  ) dut (
    .clock           (clock),
    .clear           (clear),
    .X               (X),
    .night_mode      (night_mode),
    .y2rdelay        (y2rdelay),
    .r2gdelay        (r2gdelay),
    .min_hwy_green   (min_hwy_green),
    .max_cntry_green (max_cntry_green),
    .hwy             (hwy),
    .cntry           (cntry),
    .state_o         (state_o)
  );

  always #5 clock = ~clock;

  localparam logic [2:0] S_HG = 3'd0, S_HY = 3'd1, S_AR1 = 3'd2, S_CG = 3'd3,
                         S_CY = 3'd4, S_AR2 = 3'd5, S_FL = 3'd6;

  // Expected lamp pair {hwy, cntry} for the non-flash states.
  function automatic logic [3:0] lamps(input logic [2:0] st);
    case (st)
      S_HG:    return 4'b10_00;
      S_HY:    return 4'b01_00;
      S_CG:    return 4'b00_10;
      S_CY:    return 4'b00_01;
      default: return 4'b00_00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] st, input logic [3:0] lp);
    n_tests++;
    assert ({state_o, hwy, cntry} === {st, lp})
    else begin
      n_fail++;
      $error("FAIL %s: state/hwy/cntry got %0d/%0d/%0d want %0d/%0d/%0d",
             tag, state_o, hwy, cntry, st, lp[3:2], lp[1:0]);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s[%0d]", tag, i), st, lamps(st));
    end
  endtask

  task automatic run_fl(input string tag, input logic ph, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s[%0d]", tag, i), S_FL, ph ? 4'b11_11 : 4'b01_00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
  end

  initial begin
    clear = 1'b1; X = 1'b0; night_mode = 1'b0;
    y2rdelay = 3'd3; r2gdelay = 3'd3;
    min_hwy_green = 8'd4; max_cntry_green = 8'd10;
    tick();
    tick();
    chk("reset", S_HG, 4'b10_00);
    clear = 1'b0;

    // 1: idle highway green
    run("idle_hg", S_HG, 30);

    // 2: full service cycle, X dropped in CG
    X = 1'b1;
    run("t2_hy", S_HY, 4);
    run("t2_ar1", S_AR1, 4);
    run("t2_cg", S_CG, 1);
    X = 1'b0;
    run("t2_cy", S_CY, 4);
    run("t2_ar2", S_AR2, 4);
    run("t2_hg", S_HG, 1);

    // 3: minimum green with X held high (entry cycle already observed)
    X = 1'b1;
    run("t3_hg", S_HG, 4);
    run("t3_hy", S_HY, 1);

    // 4: country timeout, then min green again, then timeout disabled
    run("t4_hy", S_HY, 3);
    run("t4_ar1", S_AR1, 4);
    run("t4_cg", S_CG, 11);
    run("t4_cy", S_CY, 4);
    run("t4_ar2", S_AR2, 4);
    run("t4_hg", S_HG, 5);
    run("t4_hy2", S_HY, 4);
    run("t4_ar1b", S_AR1, 4);
    run("t4_cg2", S_CG, 1);
    max_cntry_green = 8'd0;
    run("t4_cg_hold", S_CG, 40);

    // 5: night request in CG is deferred until HG, then flash
    night_mode = 1'b1;
    X = 1'b0;
    run("t5_cy", S_CY, 4);
    run("t5_ar2", S_AR2, 4);
    run("t5_hg", S_HG, 1);
    run_fl("t5_fl0a", 1'b0, 2);
    run_fl("t5_fl1a", 1'b1, 2);
    run_fl("t5_fl0b", 1'b0, 2);
    run_fl("t5_fl1b", 1'b1, 2);
    night_mode = 1'b0;
    run("t5_ar2x", S_AR2, 4);
    run("t5_hgx", S_HG, 3);

    // 6a: reset during CY with timer = 1
    max_cntry_green = 8'd10;
    X = 1'b1;
    run("t6_hg", S_HG, 2);
    run("t6_hy", S_HY, 4);
    run("t6_ar1", S_AR1, 4);
    run("t6_cg", S_CG, 1);
    X = 1'b0;
    run("t6_cy", S_CY, 2);
    clear = 1'b1;
    tick();
    chk("t6_clr_cy", S_HG, 4'b10_00);
    clear = 1'b0;
    X = 1'b1;
    run("t6_fresh_hg", S_HG, 4);
    run("t6_fresh_hy", S_HY, 4);
    run("t6_ar1b", S_AR1, 4);
    run("t6_cgb", S_CG, 1);
    X = 1'b0;
    run("t6_cyb", S_CY, 4);
    run("t6_ar2b", S_AR2, 4);
    run("t6_hgb", S_HG, 1);

    // 6b: reset during flash phase 1
    night_mode = 1'b1;
    run_fl("t6_fl0", 1'b0, 2);
    run_fl("t6_fl1", 1'b1, 1);
    clear = 1'b1;
    night_mode = 1'b0;
    tick();
    chk("t6_clr_fl", S_HG, 4'b10_00);
    clear = 1'b0;
    X = 1'b1;
    run("t6_fresh2_hg", S_HG, 4);
    run("t6_fresh2_hy", S_HY, 1);

    // Zero delays applied mid-yellow take effect immediately: 1-cycle dwells
    y2rdelay = 3'd0;
    r2gdelay = 3'd0;
    run("z_ar1", S_AR1, 1);
    run("z_cg", S_CG, 1);
    X = 1'b0;
    run("z_cy", S_CY, 1);
    run("z_ar2", S_AR2, 1);
    run("z_hg", S_HG, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
